// File: rtl/sao_deci_pkg.sv
// Shared constants and types for the SAO decision offset/distortion stage.
package sao_deci_pkg;

    localparam int NUM_PIX_CTU_LOG2 = 5;
    localparam int DIFF_CLIP_BIT    = 4;
    localparam int STATE_LEN        = 6;
    localparam int N_CATEGORY       = 4;
    localparam int N_CATEGORY_BO    = 8;
    localparam int N_EO_TYPE        = 4;
    localparam int DIST_LEN         = 21;
    localparam int OFF_MAX          = 7;
    localparam int NUM_ACCU_LEN     = NUM_PIX_CTU_LOG2 * 2 - 1;
    localparam int SUM_W            = NUM_ACCU_LEN + DIFF_CLIP_BIT + 1;
    localparam int NUM_W            = NUM_ACCU_LEN + 1;

    typedef logic        [STATE_LEN-1:0] cnt_t;
    typedef logic signed [3:0]           offset_t;
    typedef logic signed [DIST_LEN-1:0]  dist_t;
    typedef logic signed [SUM_W-1:0]     sum_t;
    typedef logic        [NUM_W-1:0]     num_t;

    // cnt_dc region bounds (exclusive upper ends)
    localparam cnt_t EO_END   = 6'd16;
    localparam cnt_t BO_END   = 6'd24;
    localparam cnt_t MRGL_END = 6'd28;
    localparam cnt_t MRGU_END = 6'd32;
    localparam cnt_t LAST_CNT = 6'd31;

    localparam logic signed [31:0] DIST_MAX = (32'sd1 <<< (DIST_LEN - 1)) - 32'sd1;
    localparam logic signed [31:0] DIST_MIN = -(32'sd1 <<< (DIST_LEN - 1));

    // Clamp a full-width signed value into the distortion range.
    function automatic dist_t sat_dist(input logic signed [31:0] v);
        if (v > DIST_MAX) return dist_t'(DIST_MAX);
        if (v < DIST_MIN) return dist_t'(DIST_MIN);
        return dist_t'(v);
    endfunction

endpackage

// File: rtl/sao_deci_offset_dist_if.sv
// Statistics-in / results-out bundle of the offset/distortion stage.
interface sao_deci_offset_dist_if;
    import sao_deci_pkg::*;

    logic    isWorking_deci;
    cnt_t    cnt_dc;
    sum_t    sum_blk_CTU;
    num_t    num_blk_CTU;
    offset_t L_offset [N_CATEGORY];
    offset_t U_offset [N_CATEGORY];

    offset_t eo_offset [N_EO_TYPE][N_CATEGORY];
    offset_t bo_offset [N_CATEGORY_BO];
    dist_t   eo_dist   [N_EO_TYPE];
    dist_t   bo_dist   [N_CATEGORY_BO];
    dist_t   mergeL_dist;
    dist_t   mergeU_dist;
    logic    dist_valid;

    modport master (
        output isWorking_deci, cnt_dc, sum_blk_CTU, num_blk_CTU, L_offset, U_offset,
        input  eo_offset, bo_offset, eo_dist, bo_dist, mergeL_dist, mergeU_dist, dist_valid
    );

    modport slave (
        input  isWorking_deci, cnt_dc, sum_blk_CTU, num_blk_CTU, L_offset, U_offset,
        output eo_offset, bo_offset, eo_dist, bo_dist, mergeL_dist, mergeU_dist, dist_valid
    );
endinterface

// File: rtl/sao_offset_quant.sv
// Three-stage restoring divider: mag = min(7, (|sum| + num/2) / num), 0 when num == 0.
module sao_offset_quant
    import sao_deci_pkg::*;
(
    input  logic       clk,
    input  logic       arst_n,
    input  logic       in_vld,
    input  sum_t       sum,
    input  num_t       num,
    output logic [2:0] mag,
    output logic       out_vld
);
    localparam int XW = SUM_W + 1;

    logic [SUM_W-1:0] abs_sum;
    logic [XW-1:0]    x, n8, n4;
    logic [XW-1:0]    r1, r2;
    logic [2:0]       q1, q2;
    num_t             n1, n2;
    logic             d1, d2, v1, v2;

    // Rounded dividend and the two widest divisor multiples for stage 1.
    always_comb begin
        abs_sum = sum[SUM_W-1] ? SUM_W'(-sum) : SUM_W'(sum);
        x       = {1'b0, abs_sum} + {5'b0, num[NUM_W-1:1]};
        n8      = {2'b0, num, 3'b0};
        n4      = {3'b0, num, 2'b0};
    end

    // Stage 1: saturate at 8*num (or zero divisor), else test 4*num.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            v1 <= 1'b0; n1 <= '0; q1 <= '0; d1 <= 1'b0; r1 <= '0;
        end else begin
            v1 <= in_vld;
            n1 <= num;
            if (num == '0) begin
                q1 <= 3'd0; d1 <= 1'b1; r1 <= x;
            end else if (x >= n8) begin
                q1 <= 3'(OFF_MAX); d1 <= 1'b1; r1 <= x;
            end else if (x >= n4) begin
                q1 <= 3'd4; d1 <= 1'b0; r1 <= x - n4;
            end else begin
                q1 <= 3'd0; d1 <= 1'b0; r1 <= x;
            end
        end
    end

    // Stage 2: test 2*num on the remainder.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            v2 <= 1'b0; n2 <= '0; q2 <= '0; d2 <= 1'b0; r2 <= '0;
        end else begin
            v2 <= v1;
            n2 <= n1;
            d2 <= d1;
            if (!d1 && r1 >= {4'b0, n1, 1'b0}) begin
                q2 <= q1 | 3'd2; r2 <= r1 - {4'b0, n1, 1'b0};
            end else begin
                q2 <= q1; r2 <= r1;
            end
        end
    end

    // Stage 3: test num for the final quotient bit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_vld <= 1'b0; mag <= '0;
        end else begin
            out_vld <= v2;
            mag     <= (!d2 && r2 >= {5'b0, n2}) ? (q2 | 3'd1) : q2;
        end
    end
endmodule

// File: rtl/sao_deci_offset_dist.sv
// Per-entry SAO offset derivation and distortion accumulation over cnt_dc 0..31.
module sao_deci_offset_dist
    import sao_deci_pkg::*;
(
    input  logic                   clk,
    input  logic                   arst_n,
    sao_deci_offset_dist_if.slave  bus
);
    logic    acc;
    offset_t moff_in;

    logic    s0_vld;
    cnt_t    s0_cnt;
    sum_t    s0_sum;
    num_t    s0_num;
    offset_t s0_moff;

    cnt_t    sb_cnt  [3];
    sum_t    sb_sum  [3];
    num_t    sb_num  [3];
    offset_t sb_moff [3];

    logic [2:0] q_mag;
    logic       q_vld;

    offset_t            o, magx;
    logic signed [31:0] o32, n32, s32, d_full;

    logic  s4_vld;
    cnt_t  s4_cnt;
    dist_t s4_d;

    logic [5:0] seen;
    logic       retire_last;

    // Entry qualification and merge-neighbour offset pick.
    always_comb begin
        acc     = bus.isWorking_deci && (bus.cnt_dc < MRGU_END);
        moff_in = (bus.cnt_dc >= MRGL_END) ? bus.U_offset[bus.cnt_dc[1:0]]
                                           : bus.L_offset[bus.cnt_dc[1:0]];
    end

    // S0: register the incoming entry.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s0_vld <= 1'b0; s0_cnt <= '0; s0_sum <= '0; s0_num <= '0; s0_moff <= '0;
        end else begin
            s0_vld  <= acc;
            s0_cnt  <= bus.cnt_dc;
            s0_sum  <= bus.sum_blk_CTU;
            s0_num  <= bus.num_blk_CTU;
            s0_moff <= moff_in;
        end
    end

    sao_offset_quant u_quant (
        .clk     (clk),
        .arst_n  (arst_n),
        .in_vld  (s0_vld),
        .sum     (s0_sum),
        .num     (s0_num),
        .mag     (q_mag),
        .out_vld (q_vld)
    );

    // S1-S3: carry entry side information alongside the divider.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < 3; i++) begin
                sb_cnt[i] <= '0; sb_sum[i] <= '0; sb_num[i] <= '0; sb_moff[i] <= '0;
            end
        end else begin
            sb_cnt[0] <= s0_cnt; sb_sum[0] <= s0_sum; sb_num[0] <= s0_num; sb_moff[0] <= s0_moff;
            for (int i = 1; i < 3; i++) begin
                sb_cnt[i]  <= sb_cnt[i-1];
                sb_sum[i]  <= sb_sum[i-1];
                sb_num[i]  <= sb_num[i-1];
                sb_moff[i] <= sb_moff[i-1];
            end
        end
    end

    // S4 combinational: signed/masked offset and full-width distortion.
    always_comb begin
        magx = offset_t'({1'b0, q_mag});
        o    = '0;
        if (sb_cnt[2] >= BO_END) begin
            o = sb_moff[2];
        end else if (sb_cnt[2] >= EO_END) begin
            o = sb_sum[2][SUM_W-1] ? -magx : magx;
        end else if (!sb_cnt[2][1]) begin
            o = (!sb_sum[2][SUM_W-1] && sb_sum[2] != '0) ? magx : '0;
        end else begin
            o = sb_sum[2][SUM_W-1] ? -magx : '0;
        end
        o32    = 32'(o);
        n32    = 32'(sb_num[2]);
        s32    = 32'(sb_sum[2]);
        d_full = n32 * o32 * o32 - 32'sd2 * o32 * s32;
    end

    // S4: register distortion and publish the derived offsets.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s4_vld <= 1'b0; s4_cnt <= '0; s4_d <= '0;
            for (int t = 0; t < N_EO_TYPE; t++)
                for (int c = 0; c < N_CATEGORY; c++)
                    bus.eo_offset[t][c] <= '0;
            for (int b = 0; b < N_CATEGORY_BO; b++)
                bus.bo_offset[b] <= '0;
        end else begin
            s4_vld <= q_vld;
            s4_cnt <= sb_cnt[2];
            s4_d   <= sat_dist(d_full);
            if (q_vld && sb_cnt[2] < EO_END)
                bus.eo_offset[sb_cnt[2][3:2]][sb_cnt[2][1:0]] <= o;
            else if (q_vld && sb_cnt[2] < BO_END)
                bus.bo_offset[sb_cnt[2][2:0]] <= o;
        end
    end

    // S5: accumulate per class, count retirements, and flag a complete set.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int t = 0; t < N_EO_TYPE; t++) bus.eo_dist[t] <= '0;
            for (int b = 0; b < N_CATEGORY_BO; b++) bus.bo_dist[b] <= '0;
            bus.mergeL_dist <= '0;
            bus.mergeU_dist <= '0;
            bus.dist_valid  <= 1'b0;
            seen            <= '0;
            retire_last     <= 1'b0;
        end else begin
            bus.dist_valid <= retire_last && (seen == 6'd32);
            retire_last    <= s4_vld && (s4_cnt == LAST_CNT);
            if (s4_vld) begin
                // cnt 0 starts a new set; a duplicate or missing entry leaves seen != 32
                if (s4_cnt == '0)        seen <= 6'd1;
                else if (seen != 6'h3f)  seen <= seen + 6'd1;

                if (s4_cnt < EO_END) begin
                    if (s4_cnt[1:0] == 2'd0)
                        bus.eo_dist[s4_cnt[3:2]] <= s4_d;
                    else
                        bus.eo_dist[s4_cnt[3:2]] <= sat_dist(32'(bus.eo_dist[s4_cnt[3:2]]) + 32'(s4_d));
                end else if (s4_cnt < BO_END) begin
                    bus.bo_dist[s4_cnt[2:0]] <= s4_d;
                end else if (s4_cnt < MRGL_END) begin
                    if (s4_cnt[1:0] == 2'd0) bus.mergeL_dist <= s4_d;
                    else bus.mergeL_dist <= sat_dist(32'(bus.mergeL_dist) + 32'(s4_d));
                end else begin
                    if (s4_cnt[1:0] == 2'd0) bus.mergeU_dist <= s4_d;
                    else bus.mergeU_dist <= sat_dist(32'(bus.mergeU_dist) + 32'(s4_d));
                end
            end
        end
    end
endmodule

// File: tb/tb_sao_deci_offset_dist.sv
// Scoreboard bench: sequences are modelled arithmetically, the monitor checks each result pulse.
module tb_sao_deci_offset_dist;
    import sao_deci_pkg::*;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    sao_deci_offset_dist_if bus ();

    sao_deci_offset_dist dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int eo_off [16];
        int bo_off [8];
        int eo_d   [4];
        int bo_d   [8];
        int ml;
        int mu;
        int t_pulse;
    } exp_t;

    exp_t sb_q [$];
    exp_t mon_e;

    int seq_sum [32];
    int seq_num [32];
    int seq_l   [4];
    int seq_u   [4];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp_dist(input int v);
        if (v > (1 << 20) - 1) return (1 << 20) - 1;
        if (v < -(1 << 20)) return -(1 << 20);
        return v;
    endfunction

    // Reference: offsets and distortions straight from the arithmetic rules.
    function automatic exp_t model();
        exp_t e;
        int s, n, m, o, d, a;
        for (int i = 0; i < 4; i++) e.eo_d[i] = 0;
        e.ml = 0; e.mu = 0; e.t_pulse = 0;
        for (int i = 0; i < 32; i++) begin
            s = seq_sum[i];
            n = seq_num[i];
            a = (s < 0) ? -s : s;
            if (n == 0) m = 0;
            else begin
                m = (a + n / 2) / n;
                if (m > 7) m = 7;
            end
            if (i < 16) begin
                if (i % 4 < 2) o = (s > 0) ? m : 0;
                else           o = (s < 0) ? -m : 0;
            end else if (i < 24) o = (s < 0) ? -m : m;
            else if (i < 28) o = seq_l[i - 24];
            else             o = seq_u[i - 28];
            d = clamp_dist(n * o * o - 2 * o * s);
            if (i < 16) begin
                e.eo_off[i] = o;
                e.eo_d[i / 4] = clamp_dist(e.eo_d[i / 4] + d);
            end else if (i < 24) begin
                e.bo_off[i - 16] = o;
                e.bo_d[i - 16] = d;
            end else if (i < 28) e.ml = clamp_dist(e.ml + d);
            else                 e.mu = clamp_dist(e.mu + d);
        end
        return e;
    endfunction

    // Monitor: every result pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (arst_n && bus.dist_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", int'(bus.dist_valid), 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_cycle", cyc, mon_e.t_pulse);
                for (int i = 0; i < 16; i++)
                    chk($sformatf("eo_offset[%0d][%0d]", i / 4, i % 4), int'(bus.eo_offset[i / 4][i % 4]), mon_e.eo_off[i]);
                for (int i = 0; i < 8; i++) begin
                    chk($sformatf("bo_offset[%0d]", i), int'(bus.bo_offset[i]), mon_e.bo_off[i]);
                    chk($sformatf("bo_dist[%0d]", i), int'(bus.bo_dist[i]), mon_e.bo_d[i]);
                end
                for (int i = 0; i < 4; i++)
                    chk($sformatf("eo_dist[%0d]", i), int'(bus.eo_dist[i]), mon_e.eo_d[i]);
                chk("mergeL_dist", int'(bus.mergeL_dist), mon_e.ml);
                chk("mergeU_dist", int'(bus.mergeU_dist), mon_e.mu);
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++)
                chk({tag, "_eo_offset"}, int'(bus.eo_offset[i][j]), 0);
            chk({tag, "_eo_dist"}, int'(bus.eo_dist[i]), 0);
        end
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_bo_offset"}, int'(bus.bo_offset[i]), 0);
            chk({tag, "_bo_dist"}, int'(bus.bo_dist[i]), 0);
        end
        chk({tag, "_mergeL_dist"}, int'(bus.mergeL_dist), 0);
        chk({tag, "_mergeU_dist"}, int'(bus.mergeU_dist), 0);
        chk({tag, "_dist_valid"}, int'(bus.dist_valid), 0);
    endtask

    task automatic rand_fill();
        for (int i = 0; i < 32; i++) begin
            seq_num[i] = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) == 0)
                seq_sum[i] = int'($urandom_range(0, 16383)) - 8192;
            else
                seq_sum[i] = int'($urandom_range(0, 16 * seq_num[i] + 2)) - 8 * seq_num[i] - 1;
        end
        for (int i = 0; i < 4; i++) begin
            seq_l[i] = int'($urandom_range(0, 15)) - 8;
            seq_u[i] = int'($urandom_range(0, 15)) - 8;
        end
    endtask

    task automatic drive_idle();
        @(posedge clk); #1;
        // occasionally present an out-of-range index, which must be ignored
        bus.isWorking_deci = ($urandom_range(0, 2) == 0);
        bus.cnt_dc         = cnt_t'($urandom_range(32, 63));
        bus.sum_blk_CTU    = sum_t'($urandom_range(0, 16383));
        bus.num_blk_CTU    = num_t'($urandom_range(0, 1023));
    endtask

    task automatic run_seq(input int gap_at, input int gap_len, input int skip,
                           input int last, input int abort_at, input bit rnd_gaps);
        int g;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            bus.L_offset[i] = offset_t'(seq_l[i]);
            bus.U_offset[i] = offset_t'(seq_u[i]);
        end
        for (int i = 0; i <= last; i++) begin
            if (i == skip) continue;
            if (i == abort_at) begin
                @(posedge clk); #1;
                arst_n = 1'b0;
                bus.isWorking_deci = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check_zero("abort_rst");
                @(posedge clk); #1;
                arst_n = 1'b1;
                return;
            end
            g = (i == gap_at) ? gap_len : 0;
            if (rnd_gaps && $urandom_range(0, 3) == 0) g += $urandom_range(1, 3);
            for (int k = 0; k < g; k++) drive_idle();
            @(posedge clk); #1;
            bus.isWorking_deci = 1'b1;
            bus.cnt_dc         = cnt_t'(i);
            bus.sum_blk_CTU    = sum_t'(seq_sum[i]);
            bus.num_blk_CTU    = num_t'(seq_num[i]);
            if (i == 31 && skip < 0 && abort_at < 0) begin
                e = model();
                e.t_pulse = cyc + 7;
                sb_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        bus.isWorking_deci = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("pending_results", sb_q.size(), 0);
        repeat (12) @(negedge clk);
    endtask

    task automatic setup_directed();
        rand_fill();
        seq_sum[0] = 20;  seq_num[0] = 4;
        seq_sum[1] = -5;  seq_num[1] = 3;
        seq_sum[2] = -9;  seq_num[2] = 2;
        seq_sum[3] = 33;  seq_num[3] = 0;
        seq_sum[19] = 400; seq_num[19] = 10;
        seq_sum[21] = -7;  seq_num[21] = 2;
        seq_sum[24] = 10;  seq_num[24] = 5;
        seq_sum[25] = 10;  seq_num[25] = 5;
        seq_sum[26] = -10; seq_num[26] = 5;
        seq_sum[27] = -10; seq_num[27] = 5;
        seq_l[0] = 1; seq_l[1] = 1; seq_l[2] = -1; seq_l[3] = -1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.isWorking_deci = 1'b0;
        bus.cnt_dc = '0;
        bus.sum_blk_CTU = '0;
        bus.num_blk_CTU = '0;
        for (int i = 0; i < 4; i++) begin
            bus.L_offset[i] = '0;
            bus.U_offset[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        arst_n = 1'b1;
        repeat (2) @(posedge clk);

        // directed set with a 3-cycle gap before cnt 10
        setup_directed();
        run_seq(10, 3, -1, 31, -1, 1'b0);
        drain();
        chk("tp_eo_dist0", int'(bus.eo_dist[0]), -140);
        chk("tp_eo_off00", int'(bus.eo_offset[0][0]), 5);
        chk("tp_eo_off01", int'(bus.eo_offset[0][1]), 0);
        chk("tp_eo_off02", int'(bus.eo_offset[0][2]), -5);
        chk("tp_eo_off03", int'(bus.eo_offset[0][3]), 0);
        chk("tp_bo_off3_sat", int'(bus.bo_offset[3]), 7);
        chk("tp_bo_dist3_sat", int'(bus.bo_dist[3]), -5110);
        chk("tp_bo_off5_round", int'(bus.bo_offset[5]), -4);
        chk("tp_bo_dist5_round", int'(bus.bo_dist[5]), -24);
        chk("tp_mergeL", int'(bus.mergeL_dist), -60);

        // same data back-to-back must give identical results
        run_seq(-1, 0, -1, 31, -1, 1'b0);
        drain();

        // random sequences with random bubbles and ignored out-of-range entries
        for (int r = 0; r < 6; r++) begin
            rand_fill();
            run_seq($urandom_range(0, 31), $urandom_range(0, 20), -1, 31, -1, 1'b1);
            drain();
        end

        // missing entry: no pulse
        rand_fill();
        run_seq(-1, 0, 7, 31, -1, 1'b0);
        drain();

        // sequence stops at 30, then restarts from 0: only the restart pulses
        rand_fill();
        run_seq(-1, 0, -1, 30, -1, 1'b0);
        repeat (4) @(posedge clk);
        rand_fill();
        run_seq(-1, 0, -1, 31, -1, 1'b1);
        drain();

        // async reset at cnt 20, then a fresh sequence
        rand_fill();
        run_seq(-1, 0, -1, 31, 20, 1'b0);
        repeat (10) @(negedge clk);
        check_zero("post_abort");
        rand_fill();
        run_seq(-1, 0, -1, 31, -1, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sao_deci_offset_dist.md
Name: sao_deci_offset_dist

Overview:
- Consumer of the serialized SAO decision statistics stream: one (sum, num) pair per cycle, indexed by cnt_dc.
- cnt_dc order: 0–15 EO (type = cnt>>2, cat = cnt%4); 16–23 BO bands; 24–27 merge-left; 28–31 merge-up.
- Per entry, the block derives the clipped offset (or takes the merge neighbour's offset) and computes the distortion delta.
- Accumulates per-class distortions and presents one result set to the SAO RD-cost stage after entry 31.

Parameters:
num_pix_CTU_log2, 5, log2 CTU width in pixels
diff_clip_bit, 4, extra sum bits from clipped pixel diffs
state_len, 6, cnt_dc width
n_category, 4, EO categories per type
n_category_bo, 8, candidate BO bands
n_eo_type, 4, EO types
dist_len, 21, signed distortion width
off_max, 7, offset magnitude clip
num_accu_len, num_pix_CTU_log2*2-1, derived count MSB index

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
isWorking_deci  in  1  entry-valid qualifier
cnt_dc  in  state_len  entry index 0..31
sum_blk_CTU  in  signed num_accu_len+diff_clip_bit+1  summed diff
num_blk_CTU  in  num_accu_len+1  pixel count
L_offset  in  signed 4 x[4]  left-neighbour merge offsets
U_offset  in  signed 4 x[4]  upper-neighbour merge offsets
eo_offset  out  signed 4 x[4][4]  derived EO offsets
bo_offset  out  signed 4 x[8]  derived BO offsets
eo_dist  out  signed dist_len x[4]  per-EO-type distortion
bo_dist  out  signed dist_len x[8]  per-band distortion
mergeL_dist  out  signed dist_len  left-merge distortion
mergeU_dist  out  signed dist_len  up-merge distortion
dist_valid  out  1  one-cycle pulse: result set complete

Behaviour:
- Reset: all outputs, accumulators, pipeline valids and the entry counter are 0.
- Entry accepted when isWorking_deci=1 and cnt_dc<32. cnt_dc≥32 is ignored.
- Pipeline is 5 stages; fixed latency of 5 cycles from an accepted entry to its accumulator update.
  - S0: register inputs.
  - S1–S3: restoring quotient of x=|sum|+(num>>1) by num.
    - If x≥8·num, force mag=7.
    - Otherwise S1 tests 4·num, S2 tests 2·num, S3 tests num.
    - num==0 gives mag=0.
  - S4: sign and mask, then compute dist.
  - S5: accumulate.
- Offset sign and mask rules:
  - EO cat 0,1: offset = sum>0 ? +mag : 0.
  - EO cat 2,3: offset = sum<0 ? −mag : 0.
  - BO: offset = sign(sum)·mag.
  - Merge entries (24–31) bypass the quotient: offset = L_offset/U_offset[cnt%4], aligned through the same stages.
- Distortion per entry: d = num·o² − 2·o·sum, signed, evaluated in full width, then saturated to dist_len.
- Accumulation:
  - eo_dist[cnt>>2] += d.
  - bo_dist[cnt−16] = d (a single entry per band).
  - mergeL_dist / mergeU_dist += d.
  - The cat 0 entry of each group loads rather than adds.
  - eo_offset and bo_offset register the derived offsets at S4.
- An accepted entry with cnt_dc==0 clears the seen-counter. Each retired entry increments it.
- dist_valid pulses the cycle after the cnt 31 entry retires, only if seen==32. Otherwise there is no pulse and the outputs keep their partial values.
- Back-to-back entries: one per cycle with no stall. Gaps (isWorking_deci=0) insert bubbles; results are unaffected.
- isWorking_deci dropping mid-sequence: in-flight entries still retire; no pulse unless the sequence completes later.
- Async reset mid-operation: immediate clear; no spurious dist_valid after release.
- Outputs hold their values until overwritten by the next sequence.

Decomposition:
- Package sao_deci_pkg: localparams for the cnt_dc region bounds (EO_END=16, BO_END=24, MRGL_END=28, MRGU_END=32), off_max, dist_len, and a typedef for signed offset (4-bit) and signed dist.
- Sub-module sao_offset_quant: the 3-stage saturating quotient (sum, num in; mag out, valid pipelined).

Test Plan:
- EO type0: cat0 sum=20,num=4; cat1 sum=−5,num=3; cat2 sum=−9,num=2; cat3 num=0 -> eo_offset[0] = {5,0,−5,0}; eo_dist[0] = (100−200)+0+(50−90)+0 = −140; dist_valid after entry 31.
- Saturation: BO band 3 sum=400,num=10 -> bo_offset[3]=7; bo_dist[3] = 490−5600 = −5110.
- Rounding boundary: BO sum=−7,num=2 (x=8 -> mag 4) -> offset −4, dist = 32−56 = −24.
- Merge: L_offset={1,1,−1,−1}, entries 24–27 each sum=10/−10 matching sign, num=5 -> mergeL_dist = 4·(5−20) = −60; quotient not used.
- Full 32-entry sequence with a 3-cycle isWorking_deci gap at cnt 10 -> identical results; single dist_valid pulse 6 cycles after the cnt 31 input.
- arst_n low at cnt 20, then restart at 0 -> all outputs 0 during reset; no pulse from the aborted run; correct pulse after the new entry 31.
